// File: rtl/crc_sram_scan_if.sv
// crc_sram_scan_if: job request/result and SRAM read-port signals of the CRC scanner
interface crc_sram_scan_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH:0]   len_words;
  logic                  busy;
  logic                  done;
  logic [31:0]           crc_out;
  logic                  sram_csb;
  logic                  sram_web;
  logic [NUM_WMASKS-1:0] sram_wmask;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0] sram_dout;
  modport master (
    output start, base_addr, len_words, sram_dout,
    input  busy, done, crc_out, sram_csb, sram_web, sram_wmask, sram_addr
  );
  modport slave (
    input  start, base_addr, len_words, sram_dout,
    output busy, done, crc_out, sram_csb, sram_web, sram_wmask, sram_addr
  );
endinterface

// File: rtl/crc_sram_scan.sv
// crc_sram_scan: streams a block of SRAM words through a reflected CRC-32 and publishes the result
module crc32 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic [31:0]      init,
  output logic [31:0]      crc
);
  always_comb begin
    crc = init;
    for (int i = 0; i < WIDTH; i++) crc = (crc >> 1) ^ ((crc[0] ^ data_in[i]) ? 32'hEDB88320 : 32'h0);
  end
endmodule

module crc_sram_scan #(
  parameter int          ADDR_WIDTH = 10,
  parameter int          DATA_WIDTH = 32,
  parameter int          NUM_WMASKS = 4,
  parameter logic [31:0] CRC_INIT   = 32'hFFFFFFFF,
  parameter logic [31:0] CRC_XOROUT = 32'hFFFFFFFF
) (
  input logic            clk0,
  input logic            rst_n,
  crc_sram_scan_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  state_t              state;
  logic [ADDR_WIDTH:0] remaining;
  logic                rd_vld;
  logic                drain_hold;
  logic [31:0]         crc_reg;
  logic [31:0]         crc_next;
  crc32 #(.WIDTH(DATA_WIDTH)) u_crc (.data_in(bus.sram_dout), .init(crc_reg), .crc(crc_next));
  assign bus.sram_web   = 1'b1;
  assign bus.sram_wmask = '0;
  // DRAIN always lasts two cycles: one to fold the last word (if any), one so done lands N+2 cycles after start
  always_ff @(posedge clk0 or negedge rst_n)
    if (!rst_n) begin
      state         <= IDLE;
      remaining     <= '0;
      rd_vld        <= 1'b0;
      drain_hold    <= 1'b0;
      crc_reg       <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.crc_out   <= '0;
      bus.sram_csb  <= 1'b1;
      bus.sram_addr <= '0;
    end else begin
      rd_vld   <= state == READ;
      bus.done <= 1'b0;
      if (rd_vld) crc_reg <= crc_next;
      case (state)
        IDLE: if (bus.start) begin
          bus.sram_addr <= bus.base_addr;
          remaining     <= bus.len_words;
          crc_reg       <= CRC_INIT;
          bus.busy      <= 1'b1;
          bus.sram_csb  <= bus.len_words == 0;
          drain_hold    <= 1'b0;
          state         <= bus.len_words == 0 ? DRAIN : READ;
        end
        READ: begin
          bus.sram_addr <= bus.sram_addr + 1'b1;
          remaining     <= remaining - 1'b1;
          if (remaining == 1) begin
            bus.sram_csb <= 1'b1;
            state        <= DRAIN;
          end
        end
        DRAIN: begin
          drain_hold <= 1'b1;
          if (drain_hold) begin
            bus.busy    <= 1'b0;
            bus.done    <= 1'b1;
            bus.crc_out <= crc_reg ^ CRC_XOROUT;
            state       <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_crc_sram_scan.sv
// tb_crc_sram_scan: directed jobs against an SRAM model and a byte-wise CRC-32 reference
module tb_crc_sram_scan;
  logic clk0 = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic [31:0] mem [1024];
  int addr_log[$];
  int stamp_log[$];
  crc_sram_scan_if bus ();
  crc_sram_scan dut (.clk0(clk0), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk0 = ~clk0;
  always @(posedge clk0) if (!bus.sram_csb) bus.sram_dout <= mem[bus.sram_addr];
  always @(negedge clk0) begin
    cyc <= cyc + 1;
    if (!bus.sram_csb) begin
      addr_log.push_back(int'(bus.sram_addr));
      stamp_log.push_back(cyc);
    end
    if (bus.done) done_cnt <= done_cnt + 1;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] model_crc(input int base, input int len);
    logic [31:0] c = 32'hFFFFFFFF;
    logic [31:0] w;
    for (int i = 0; i < len; i++) begin
      w = mem[(base + i) % 1024];
      for (int b = 0; b < 4; b++) begin
        c = c ^ {24'h0, w[8*b +: 8]};
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
    end
    return c ^ 32'hFFFFFFFF;
  endfunction
  task automatic run_job(input int base, input int len, input string tag);
    int lat;
    int bad;
    logic [31:0] exp_crc;
    exp_crc = model_crc(base, len);
    @(negedge clk0);
    bus.start = 1'b1;
    bus.base_addr = base[9:0];
    bus.len_words = len[10:0];
    addr_log.delete();
    stamp_log.delete();
    @(negedge clk0);
    bus.start = 1'b0;
    check({tag, "_busy"}, bus.busy, 1'b1);
    lat = 0;
    while (!bus.done && lat < 1100) begin
      @(negedge clk0);
      lat++;
    end
    check({tag, "_latency"}, lat, len + 2);
    check({tag, "_crc"}, bus.crc_out, exp_crc);
    check({tag, "_busy_at_done"}, bus.busy, 1'b0);
    check({tag, "_nreads"}, addr_log.size(), len);
    bad = 0;
    for (int i = 0; i < addr_log.size(); i++) if (addr_log[i] != (base + i) % 1024) bad++;
    check({tag, "_addr_seq_bad"}, bad, 0);
    if (len > 0) check({tag, "_contiguous"}, stamp_log[stamp_log.size()-1] - stamp_log[0], len - 1);
    @(negedge clk0);
    check({tag, "_done_pulse"}, bus.done, 1'b0);
  endtask
  initial begin
    int d0;
    int lat;
    logic [31:0] cap;
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.len_words = '0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[5] = 32'h0;
    repeat (2) @(negedge clk0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_crc_out", bus.crc_out, 32'h0);
    check("rst_csb", bus.sram_csb, 1'b1);
    check("rst_addr", bus.sram_addr, 32'h0);
    check("web_tied", bus.sram_web, 1'b1);
    check("wmask_tied", bus.sram_wmask, 32'h0);
    rst_n = 1'b1;
    run_job(0, 0, "len0");
    check("len0_crc_const", bus.crc_out, 32'h00000000);
    run_job(5, 1, "zero_word");
    check("zero_word_const", bus.crc_out, 32'h2144DF1C);
    run_job(0, 1024, "full");
    run_job(1022, 4, "wrap");
    // second start mid-job and in the done cycle must both be dropped
    cap = model_crc(100, 8);
    d0 = done_cnt;
    @(negedge clk0);
    bus.start = 1'b1;
    bus.base_addr = 10'd100;
    bus.len_words = 11'd8;
    @(negedge clk0);
    bus.start = 1'b0;
    repeat (3) @(negedge clk0);
    bus.start = 1'b1;
    bus.base_addr = 10'd0;
    bus.len_words = 11'd1;
    @(negedge clk0);
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 100) begin
      @(negedge clk0);
      lat++;
    end
    check("restart_crc", bus.crc_out, cap);
    bus.start = 1'b1;
    bus.base_addr = 10'd200;
    bus.len_words = 11'd2;
    @(negedge clk0);
    bus.start = 1'b0;
    check("restart_idle_busy", bus.busy, 1'b0);
    repeat (6) @(negedge clk0);
    check("restart_one_done", done_cnt - d0, 1);
    check("restart_still_idle", bus.busy, 1'b0);
    check("restart_crc_held", bus.crc_out, cap);
    @(negedge clk0);
    bus.start = 1'b1;
    bus.base_addr = 10'd0;
    bus.len_words = 11'd1024;
    @(negedge clk0);
    bus.start = 1'b0;
    repeat (10) @(negedge clk0);
    check("pre_rst_csb", bus.sram_csb, 1'b0);
    rst_n = 1'b0;
    #1;
    check("arst_csb", bus.sram_csb, 1'b1);
    check("arst_busy", bus.busy, 1'b0);
    check("arst_done", bus.done, 1'b0);
    check("arst_crc_out", bus.crc_out, 32'h0);
    @(negedge clk0);
    rst_n = 1'b1;
    d0 = done_cnt;
    repeat (20) @(negedge clk0);
    check("abandoned_no_done", done_cnt - d0, 0);
    run_job(1022, 4, "post_rst_wrap");
    run_job(3, 5, "post_rst_small");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
